// File: rtl/prpg_pkg.sv
// Shared types, opcodes and the signature update step for the LFSR pattern
// generator and its downstream MISR compaction stage.
package prpg_pkg;

    localparam int unsigned W = 8;

    typedef logic [0:W-1] pat_t;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} misr_state_e;

    localparam logic [2:0] CFG_TAP   = 3'd0;
    localparam logic [2:0] INIT_L    = 3'd1;
    localparam logic [2:0] RUN       = 3'd2;
    localparam logic [2:0] STORE     = 3'd3;
    localparam logic [2:0] LOAD      = 3'd4;
    localparam logic [2:0] INIT_ADDR = 3'd5;
    localparam logic [2:0] ADD_ADDR  = 3'd6;
    localparam logic [2:0] HALT      = 3'd7;

    // One MISR step: bit 7 is the feedback, tap[6] feeds bit 1 ... tap[0] feeds bit 7.
    function automatic pat_t misr_next(pat_t s, pat_t d, logic [6:0] tap);
        pat_t r;
        logic fb;
        fb   = s[7];
        r[0] = fb ^ d[0];
        for (int i = 1; i < 8; i++) begin
            r[3'(i)] = s[3'(i - 1)] ^ (tap[3'(7 - i)] & fb) ^ d[3'(i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/prpg_misr_core.sv
// Signature register: reloads SEED on load_i, folds d_i in on en_i.
module prpg_misr_core
    import prpg_pkg::*;
#(
    parameter pat_t SEED = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       en_i,
    input  logic [6:0] tap_i,
    input  pat_t       d_i,
    output pat_t       sig_o,
    output pat_t       sig_nxt_c
);

    pat_t sig_q;
    pat_t sig_d;

    assign sig_nxt_c = misr_next(sig_q, d_i, tap_i);

    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = SEED;
        end else if (en_i) begin
            sig_d = sig_nxt_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/prpg_sig_misr.sv
// BIST response compactor: collects pat_cnt valid patterns into a MISR, then
// freezes the signature and flags whether it matched the expected value.
module prpg_sig_misr
    import prpg_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter pat_t        SEED  = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       cfg_tap,
    input  logic [CNT_W-1:0] pat_cnt,
    input  pat_t             exp_sig,
    input  pat_t             q_in,
    input  logic             q_valid,
    output pat_t             sig,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    misr_state_e      state_q;
    logic [CNT_W-1:0] rem_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [6:0]       tap_q;
    pat_t             exp_q;

    logic load_c;
    logic cap_c;
    pat_t sig_nxt_c;

    assign load_c = (state_q != COLLECT) && start;
    assign cap_c  = (state_q == COLLECT) && q_valid;

    prpg_misr_core #(
        .SEED(SEED)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load_c),
        .en_i     (cap_c),
        .tap_i    (tap_q),
        .d_i      (q_in),
        .sig_o    (sig),
        .sig_nxt_c(sig_nxt_c)
    );

    // Control FSM; status flags are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tap_q   <= '0;
            exp_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        rem_q  <= pat_cnt;
                        tap_q  <= cfg_tap;
                        exp_q  <= exp_sig;
                        pass_q <= 1'b0;
                        if (pat_cnt != '0) begin
                            state_q <= COLLECT;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (SEED == exp_sig);
                        end
                    end
                end
                COLLECT: begin
                    if (q_valid) begin
                        rem_q <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (sig_nxt_c == exp_q);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign remaining = rem_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;

endmodule
